// File: rtl/downcount_timer.sv
// ---------------------------------------------------------------------------
// downcount_timer
//
// Loadable 5-bit down-counter with a three-state controller (IDLE/RUN/DONE).
// Load copies D into the count and parks the FSM in IDLE. Start kicks off a
// countdown that decrements once per enabled cycle. When the count reaches 0
// the FSM spends exactly one cycle in DONE.
//
// Build option:
//   DOWNCOUNT_RELOAD_EN  - when defined, a reload register captures D on every
//                          Load. On leaving DONE the count is restored from it
//                          and the timer keeps running (period N+1) unless the
//                          reload value is 0. When undefined (default), the
//                          timer is one-shot and DONE always returns to IDLE.
//
// Ports:
//   Clock     in   1  rising-edge clock
//   Reset     in   1  synchronous, active-high reset (highest priority)
//   count_en  in   1  decrement enable, only looked at in RUN
//   Load      in   1  load request: Q <= D, state <= IDLE
//   D         in   5  load value (unsigned)
//   Start     in   1  start countdown request, only acted on in IDLE
//   Q         out  5  current count (registered)
//   Busy      out  1  state == RUN
//   Done      out  1  state == DONE (one cycle per completion)
//   Zero      out  1  Q == 0 (combinational)
// ---------------------------------------------------------------------------
module downcount_timer (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       count_en,
    input  logic       Load,
    input  logic [4:0] D,
    input  logic       Start,
    output logic [4:0] Q,
    output logic       Busy,
    output logic       Done,
    output logic       Zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Declaration initialisers give the reset state at power-up, before the
    // first synchronous Reset is seen.
    state_t     state = IDLE;
    state_t     state_next;
    logic [4:0] q_reg = 5'd0;
    logic [4:0] q_next;
`ifdef DOWNCOUNT_RELOAD_EN
    logic [4:0] reload = 5'd0;
    logic [4:0] reload_next;
`endif

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge values; blocking here would create
    // order-dependent simulation that does not match the synthesised flops.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            q_reg  <= 5'd0;
`ifdef DOWNCOUNT_RELOAD_EN
            reload <= 5'd0;
`endif
        end else begin
            state  <= state_next;
            q_reg  <= q_next;
`ifdef DOWNCOUNT_RELOAD_EN
            reload <= reload_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / next-count logic. Priority below Reset: Load > Start > count.
    // -----------------------------------------------------------------------
    // NOTE: every variable gets its hold value first, so no path through the
    // case/if tree leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        q_next      = q_reg;
`ifdef DOWNCOUNT_RELOAD_EN
        reload_next = reload;
`endif

        if (Load) begin
            // Load aborts whatever is in progress; a coincident Start is lost.
            q_next     = D;
            state_next = IDLE;
`ifdef DOWNCOUNT_RELOAD_EN
            reload_next = D;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        // A zero count has nothing to run; go straight to DONE.
                        state_next = (q_reg != 5'd0) ? RUN : DONE;
                    end
                end

                RUN: begin
                    if (count_en) begin
                        // RUN is only entered with a nonzero count, but the
                        // <=1 test also keeps a stray 0 from wrapping.
                        if (q_reg <= 5'd1) begin
                            q_next     = 5'd0;
                            state_next = DONE;
                        end else begin
                            q_next = q_reg - 5'd1;
                        end
                    end
                end

                DONE: begin
`ifdef DOWNCOUNT_RELOAD_EN
                    q_next     = reload;
                    state_next = (reload != 5'd0) ? RUN : IDLE;
`else
                    state_next = IDLE;
`endif
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign Q    = q_reg;
    assign Busy = (state == RUN);
    assign Done = (state == DONE);
    assign Zero = (q_reg == 5'd0);

endmodule

// File: tb/tb_downcount_timer.sv
// ---------------------------------------------------------------------------
// tb_downcount_timer
//
// Directed-vector bench for downcount_timer. A driver applies one set of
// inputs per cycle (on the falling edge) and queues the hand-computed
// {Q, Busy, Done, Zero} expected after the following rising edge. An
// independent monitor pops one entry per cycle, shortly after the rising
// edge, and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_downcount_timer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       count_en = 1'b0;
    logic       Load = 1'b0;
    logic [4:0] D = 5'd0;
    logic       Start = 1'b0;
    logic [4:0] Q;
    logic       Busy;
    logic       Done;
    logic       Zero;

    typedef struct packed {
        logic [4:0] q;
        logic       busy;
        logic       done;
        logic       zero;
    } obs_t;

    obs_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   vec_idx = 0;

    downcount_timer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .count_en (count_en),
        .Load     (Load),
        .D        (D),
        .Start    (Start),
        .Q        (Q),
        .Busy     (Busy),
        .Done     (Done),
        .Zero     (Zero)
    );

    always #5 Clock = ~Clock;

    // Queue the expected outputs after the next rising edge.
    task automatic expect_next(input logic [4:0] eq, input logic eb, input logic ed);
        obs_t e;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        e.zero = (eq == 5'd0);
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus plus its expected result.
    task automatic step(input logic rst, input logic ld, input logic [4:0] d,
                        input logic st, input logic en,
                        input logic [4:0] eq, input logic eb, input logic ed);
        @(negedge Clock);
        Reset    = rst;
        Load     = ld;
        D        = d;
        Start    = st;
        count_en = en;
        expect_next(eq, eb, ed);
    endtask

    // Monitor / scoreboard
    initial begin
        obs_t e;
        obs_t act;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {Q, Busy, Done, Zero};
                tests_run++;
                if (act !== e) begin
                    tests_failed++;
                    $display("FAIL vec%0d @%0t: got Q=%0d Busy=%b Done=%b Zero=%b, expected Q=%0d Busy=%b Done=%b Zero=%b",
                             vec_idx, $time, act.q, act.busy, act.done, act.zero,
                             e.q, e.busy, e.done, e.zero);
                end
                vec_idx++;
            end
        end
    end

    // Driver
    initial begin
        // Power-up state, observed after the first edge with all inputs low.
        expect_next(5'd0, 1'b0, 1'b0);

        // Reset wins over Load/Start/count_en.
        //   rst ld  d     st   en    Q     Busy Done
        step(1, 1, 5'd7, 1, 1,  5'd0, 0, 0);
        step(0, 0, 5'd0, 0, 0,  5'd0, 0, 0);

        // Zero load then Start: DONE for one cycle, never Busy.
        step(0, 1, 5'd0, 0, 1,  5'd0, 0, 0);
        step(0, 0, 5'd0, 1, 1,  5'd0, 0, 1);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 0);

`ifdef DOWNCOUNT_RELOAD_EN
        // Auto-reload with D=2: Q 2,1,0,2,1,0 with Done every third cycle.
        step(0, 1, 5'd2, 0, 1,  5'd2, 0, 0);
        step(0, 0, 5'd0, 1, 1,  5'd2, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd1, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 1);
        step(0, 0, 5'd0, 0, 1,  5'd2, 1, 0);
        step(0, 0, 5'd0, 1, 1,  5'd1, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 1);
        step(0, 0, 5'd0, 0, 1,  5'd2, 1, 0);
        step(0, 0, 5'd0, 0, 0,  5'd2, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd1, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 1);
        // Load D=0 while in DONE: parks in IDLE, reload now 0.
        step(0, 1, 5'd0, 0, 1,  5'd0, 0, 0);
        step(0, 0, 5'd0, 1, 1,  5'd0, 0, 1);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 0);
`else
        // D=5, count_en held: Busy 5 cycles, Q 4..0, single Done, Start in RUN ignored.
        step(0, 1, 5'd5, 0, 1,  5'd5, 0, 0);
        step(0, 0, 5'd0, 1, 1,  5'd5, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd4, 1, 0);
        step(0, 0, 5'd0, 1, 1,  5'd3, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd2, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd1, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 1);
        // Start while in DONE is ignored: back to IDLE.
        step(0, 0, 5'd0, 1, 1,  5'd0, 0, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 0);

        // D=3 with count_en 1,0,1,0,1: holds on disabled cycles.
        step(0, 1, 5'd3, 0, 0,  5'd3, 0, 0);
        step(0, 0, 5'd0, 1, 0,  5'd3, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd2, 1, 0);
        step(0, 0, 5'd0, 0, 0,  5'd2, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd1, 1, 0);
        step(0, 0, 5'd0, 0, 0,  5'd1, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 1);
        step(0, 0, 5'd0, 0, 0,  5'd0, 0, 0);

        // D=6, two decrements, then Load D=9 with Start: abort to IDLE.
        step(0, 1, 5'd6, 0, 0,  5'd6, 0, 0);
        step(0, 0, 5'd0, 1, 1,  5'd6, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd5, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd4, 1, 0);
        step(0, 1, 5'd9, 1, 1,  5'd9, 0, 0);
        // No decrement outside RUN.
        step(0, 0, 5'd0, 0, 1,  5'd9, 0, 0);
        // Restart, then Reset mid-RUN: no Done afterwards.
        step(0, 0, 5'd0, 1, 1,  5'd9, 1, 0);
        step(0, 0, 5'd0, 0, 1,  5'd8, 1, 0);
        step(1, 0, 5'd0, 0, 1,  5'd0, 0, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 0);
        step(0, 0, 5'd0, 0, 1,  5'd0, 0, 0);
`endif

        // Drain the scoreboard with a bounded wait.
        @(negedge Clock);
        Reset    = 1'b0;
        Load     = 1'b0;
        Start    = 1'b0;
        count_en = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
        #2;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expected vectors never compared, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
